// File: rtl/bzmusic_note_gen.sv
// Note generator: plays one square-wave note of latched tune/beat with an
// articulation gap, then reports completion with a single beat_finish pulse.
module bzmusic_note_gen #(
    parameter int unsigned TUNE_W    = 16,
    parameter int unsigned BEAT_W    = 8,
    parameter int unsigned TICK_DIV  = 50000,
    parameter int unsigned GAP_TICKS = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              tune_pwm_en,
    input  logic              tune_pwm_rstn,
    input  logic              beat_cnt_en,
    input  logic              beat_cnt_rstn,
    input  logic [TUNE_W-1:0] tune,
    input  logic [BEAT_W-1:0] beat,
    output logic              buzzer,
    output logic              beat_finish,
    output logic              note_busy
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned GAP_U = GAP_TICKS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PRE_W-1:0]  pre;
    logic [PRE_W-1:0]  pre_nxt;
    logic [BEAT_W-1:0] bt;
    logic [BEAT_W-1:0] bt_nxt;
    logic [BEAT_W-1:0] len_q;
    logic [BEAT_W-1:0] len_nxt;
    logic [TUNE_W-1:0] hc;
    logic [TUNE_W-1:0] hc_nxt;
    logic [TUNE_W-1:0] tune_q;
    logic [TUNE_W-1:0] tune_nxt;
    logic              buzzer_nxt;
    logic              finish_nxt;
    logic              busy_nxt;
    logic              mute_nxt;
    logic              tone_clr;
    logic              clr;
    logic              tick;
    logic              last;

    assign clr  = !rstn || !beat_cnt_rstn;
    assign tick = (pre == PRE_W'(TICK_DIV - 1));
    assign last = (bt == len_q - BEAT_W'(1));

    // State register
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (beat_cnt_en) state_nxt = RUN;
            RUN:  if (beat_cnt_en && tick && last) state_nxt = DONE;
            DONE: state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counter and output next values
    always_comb begin
        pre_nxt    = pre;
        bt_nxt     = bt;
        len_nxt    = len_q;
        tune_nxt   = tune_q;
        hc_nxt     = hc;
        buzzer_nxt = buzzer;
        finish_nxt = 1'b0;
        busy_nxt   = (state_nxt == RUN);

        case (state)
            IDLE: begin
                pre_nxt = '0;
                bt_nxt  = '0;
                if (beat_cnt_en) begin
                    tune_nxt = tune;
                    len_nxt  = (beat == '0) ? BEAT_W'(1) : beat;
                end
            end
            RUN: begin
                if (beat_cnt_en) begin
                    if (tick) begin
                        pre_nxt = '0;
                        if (last) begin
                            finish_nxt = 1'b1;
                        end else begin
                            bt_nxt = bt + BEAT_W'(1);
                        end
                    end else begin
                        pre_nxt = pre + PRE_W'(1);
                    end
                end
            end
            default: begin
                pre_nxt = '0;
                bt_nxt  = '0;
            end
        endcase

        // Gap is evaluated on next-cycle counters so buzzer is already low when it starts
        mute_nxt = (32'(len_nxt) > GAP_U) && ((32'(bt_nxt) + GAP_U) >= 32'(len_nxt));
        tone_clr = (state != RUN) || (state_nxt != RUN) || mute_nxt ||
                   (tune_q == '0) || !tune_pwm_rstn;

        if (tone_clr) begin
            hc_nxt     = '0;
            buzzer_nxt = 1'b0;
        end else if (tune_pwm_en) begin
            if (hc == tune_q - TUNE_W'(1)) begin
                hc_nxt     = '0;
                buzzer_nxt = ~buzzer;
            end else begin
                hc_nxt = hc + TUNE_W'(1);
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (clr) begin
            pre         <= '0;
            bt          <= '0;
            len_q       <= '0;
            tune_q      <= '0;
            hc          <= '0;
            buzzer      <= 1'b0;
            beat_finish <= 1'b0;
            note_busy   <= 1'b0;
        end else begin
            pre         <= pre_nxt;
            bt          <= bt_nxt;
            len_q       <= len_nxt;
            tune_q      <= tune_nxt;
            hc          <= hc_nxt;
            buzzer      <= buzzer_nxt;
            beat_finish <= finish_nxt;
            note_busy   <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_bzmusic_note_gen.sv
// Bench for bzmusic_note_gen: elapsed-time reference model checked every cycle,
// plus directed literal checks of note timing.
module tb_bzmusic_note_gen;

    localparam int unsigned TUNE_W = 16;
    localparam int unsigned BEAT_W = 8;
    localparam int TD  = 4;
    localparam int GAP = 1;

    logic              clk = 1'b0;
    logic              rstn;
    logic              tune_pwm_en;
    logic              tune_pwm_rstn;
    logic              beat_cnt_en;
    logic              beat_cnt_rstn;
    logic [TUNE_W-1:0] tune;
    logic [BEAT_W-1:0] beat;
    logic              buzzer;
    logic              beat_finish;
    logic              note_busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int t0     = 0;

    bzmusic_note_gen #(
        .TUNE_W   (TUNE_W),
        .BEAT_W   (BEAT_W),
        .TICK_DIV (TD),
        .GAP_TICKS(GAP)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .tune_pwm_en  (tune_pwm_en),
        .tune_pwm_rstn(tune_pwm_rstn),
        .beat_cnt_en  (beat_cnt_en),
        .beat_cnt_rstn(beat_cnt_rstn),
        .tune         (tune),
        .beat         (beat),
        .buzzer       (buzzer),
        .beat_finish  (beat_finish),
        .note_busy    (note_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: note progress measured as elapsed counting cycles
    bit m_act  = 1'b0;
    bit m_done = 1'b0;
    bit m_buz  = 1'b0;
    bit m_fin  = 1'b0;
    int m_e    = 0;
    int m_ph   = 0;
    int m_len  = 0;
    int m_tq   = 0;

    always @(posedge clk) begin
        int e2;
        if (!rstn || !beat_cnt_rstn) begin
            m_act = 1'b0; m_done = 1'b0; m_e = 0; m_ph = 0; m_buz = 1'b0; m_fin = 1'b0;
        end else if (m_act) begin
            m_fin = 1'b0;
            e2 = m_e + (beat_cnt_en ? 1 : 0);
            if (e2 == m_len * TD) begin
                m_act = 1'b0; m_done = 1'b1; m_fin = 1'b1; m_buz = 1'b0; m_ph = 0;
            end else if ((m_len > GAP && e2 >= (m_len - GAP) * TD) || m_tq == 0 || !tune_pwm_rstn) begin
                m_buz = 1'b0; m_ph = 0;
            end else if (tune_pwm_en) begin
                m_ph = m_ph + 1;
                if (m_ph == m_tq) begin
                    m_ph  = 0;
                    m_buz = !m_buz;
                end
            end
            m_e = e2;
        end else if (m_done) begin
            m_fin = 1'b0; m_buz = 1'b0;
        end else begin
            m_fin = 1'b0;
            if (beat_cnt_en) begin
                m_act = 1'b1;
                m_tq  = int'(tune);
                m_len = (beat == '0) ? 1 : int'(beat);
                m_e   = 0; m_ph = 0; m_buz = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at cycle %0d (t0+%0d)", nm, act, exp, cyc, cyc - t0);
        end
    endtask

    // Advance one cycle and compare outputs against the model
    task automatic step();
        @(posedge clk);
        #1;
        chk("model_buzzer", buzzer, m_buz);
        chk("model_beat_finish", beat_finish, m_fin);
        chk("model_note_busy", note_busy, m_act);
    endtask

    task automatic wait_rel(input int k);
        while (cyc < t0 + k) step();
    endtask

    task automatic restart(input int t, input int b);
        beat_cnt_rstn = 1'b0;
        tune = TUNE_W'(t);
        beat = BEAT_W'(b);
        step();
        beat_cnt_rstn = 1'b1;
        step();
        t0 = cyc;
    endtask

    initial begin
        rstn = 1'b0; beat_cnt_rstn = 1'b1; beat_cnt_en = 1'b1;
        tune_pwm_en = 1'b1; tune_pwm_rstn = 1'b1;
        tune = 16'd3; beat = 8'd4;
        repeat (3) step();
        chk("reset_buzzer", buzzer, 1'b0);
        chk("reset_finish", beat_finish, 1'b0);
        chk("reset_busy", note_busy, 1'b0);

        // Basic note, later input changes must be ignored
        rstn = 1'b1;
        step();
        t0 = cyc;
        chk("start_busy", note_busy, 1'b1);
        chk("start_buzzer", buzzer, 1'b0);
        tune = 16'd7; beat = 8'd9;
        wait_rel(3);  chk("basic_rise3", buzzer, 1'b1);
        wait_rel(6);  chk("basic_fall6", buzzer, 1'b0);
        wait_rel(9);  chk("basic_rise9", buzzer, 1'b1);
        wait_rel(12); chk("basic_mute12", buzzer, 1'b0);
        wait_rel(15); chk("basic_mute15", buzzer, 1'b0);
                      chk("basic_nofin15", beat_finish, 1'b0);
        wait_rel(16); chk("basic_fin16", beat_finish, 1'b1);
                      chk("basic_busy16", note_busy, 1'b0);
        wait_rel(17); chk("basic_fin17", beat_finish, 1'b0);
        wait_rel(26); chk("done_hold_fin", beat_finish, 1'b0);
                      chk("done_hold_buz", buzzer, 1'b0);
                      chk("done_hold_busy", note_busy, 1'b0);

        // Rest note
        restart(0, 2);
        chk("rest_busy", note_busy, 1'b1);
        wait_rel(3);  chk("rest_buz", buzzer, 1'b0);
        wait_rel(7);  chk("rest_nofin7", beat_finish, 1'b0);
        wait_rel(8);  chk("rest_fin8", beat_finish, 1'b1);

        // Zero beat behaves as one tick, no gap
        restart(2, 0);
        wait_rel(2);  chk("beat0_rise2", buzzer, 1'b1);
        wait_rel(3);  chk("beat0_high3", buzzer, 1'b1);
        wait_rel(4);  chk("beat0_fin4", beat_finish, 1'b1);

        // One-tick note, tone runs to the end
        restart(1, 1);
        wait_rel(3);  chk("beat1_tone3", buzzer, 1'b1);
        wait_rel(4);  chk("beat1_fin4", beat_finish, 1'b1);
                      chk("beat1_buz4", buzzer, 1'b0);

        // Pause stretches the note
        restart(3, 4);
        wait_rel(6);  beat_cnt_en = 1'b0;
        wait_rel(11); beat_cnt_en = 1'b1;
        wait_rel(20); chk("pause_nofin20", beat_finish, 1'b0);
        wait_rel(21); chk("pause_fin21", beat_finish, 1'b1);

        // Abort mid-note, then start a new note with a new tune
        restart(3, 4);
        wait_rel(7);  beat_cnt_rstn = 1'b0; tune = 16'd2;
        wait_rel(8);  chk("abort_busy", note_busy, 1'b0);
                      chk("abort_buz", buzzer, 1'b0);
                      chk("abort_fin", beat_finish, 1'b0);
        beat_cnt_rstn = 1'b1;
        step();
        t0 = cyc;
        wait_rel(2);  chk("abort_new_rise2", buzzer, 1'b1);
        wait_rel(4);  chk("abort_new_fall4", buzzer, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rstn          = ($urandom_range(199) != 0);
            beat_cnt_rstn = ($urandom_range(39) != 0);
            beat_cnt_en   = ($urandom_range(7) != 0);
            tune_pwm_en   = ($urandom_range(9) != 0);
            tune_pwm_rstn = ($urandom_range(29) != 0);
            tune          = TUNE_W'($urandom_range(5));
            beat          = BEAT_W'($urandom_range(5));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bzmusic_note_gen.md
# bzmusic_note_gen

Note generator for the buzzer music player, directly downstream of the music sequencer controller. It consumes the controller's `tune_pwm_*` and `beat_cnt_*` enable and soft-reset strobes, and the current tune and beat codes from the score registers. It drives the square-wave buzzer output for one note, including an articulation gap at the note end, then returns a single-cycle `beat_finish` to the controller.

## Interface
Parameters:
- `TUNE_W`, 16, width of tune code (half-period in clk cycles)
- `BEAT_W`, 8, width of beat code (note length in ticks)
- `TICK_DIV`, 50000, clk cycles per beat tick (≥2)
- `GAP_TICKS`, 1, silent ticks at end of each note (≥0)

Ports:
- `clk` in 1: system clock
- `rstn` in 1: reset, **synchronous, active-low**
- `tune_pwm_en` in 1: tone generator enable
- `tune_pwm_rstn` in 1: tone generator soft clear, sync active-low
- `beat_cnt_en` in 1: beat counter enable (0 = pause)
- `beat_cnt_rstn` in 1: beat counter soft clear, sync active-low
- `tune` in TUNE_W: half-period code; 0 = rest
- `beat` in BEAT_W: length in ticks; 0 treated as 1
- `buzzer` out 1: square-wave output (registered)
- `beat_finish` out 1: one-cycle note-complete pulse (registered)
- `note_busy` out 1: high while state == RUN

## Operation
- Priority: `rstn`=0 > `beat_cnt_rstn`=0 > normal operation.
- `rstn`=0 or `beat_cnt_rstn`=0 sets the state to IDLE and clears all counters, `buzzer`, and `beat_finish`.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN when `beat_cnt_rstn`=1 and `beat_cnt_en`=1. On this transition, latch `tune_q`=`tune` and `len_q`=(`beat`==0 ? 1 : `beat`).
  - RUN→DONE on the final tick.
  - DONE holds with `buzzer`=0 until a soft or hard clear. There is no second `beat_finish` pulse.
- Prescaler `pre` counts 0..TICK_DIV-1 in RUN while `beat_cnt_en`=1. `tick` = (`pre`==TICK_DIV-1). `pre` wraps to 0 on `tick`.
- Tick counter `bt` (BEAT_W bits) increments on `tick`. The final tick is the `tick` with `bt`==`len_q`-1.
- Gap: `mute` = (`len_q` > GAP_TICKS) and (`bt` ≥ `len_q`-GAP_TICKS). If `len_q` ≤ GAP_TICKS, the note has no gap.
- Tone: half counter `hc` (TUNE_W bits) advances only when all of the following hold: state RUN, `tune_pwm_en`=1, `tune_pwm_rstn`=1, `tune_q`≠0, and not `mute`.
  - When advancing: at `hc`==`tune_q`-1, `hc` goes to 0 and `buzzer` toggles; otherwise `hc` increments.
- `tune_pwm_rstn`=0 clears `hc` and `buzzer`.
- `tune_pwm_en`=0 (with `tune_pwm_rstn`=1) freezes `hc` and `buzzer`.
- `mute`, `tune_q`=0, IDLE, or DONE clear `hc` and force `buzzer`=0.
- `beat_cnt_en`=0 in RUN freezes `pre` and `bt`. The tone is governed solely by its own enables.
- `tune` and `beat` input changes after latching have no effect on the current note.

## Timing
- All outputs reset to 0. The state resets to IDLE.
- Let t0 be the first cycle with state==RUN.
  - `pre`=0, `bt`=0, `hc`=0 at t0.
  - `note_busy`=1 from t0.
- First buzzer rise at t0+`tune_q`. Toggles every `tune_q` cycles after that, so the period is 2·`tune_q`.
- Tick k (k=1..) occurs at cycle t0+k·TICK_DIV-1.
- Mute begins (`buzzer`=0) at t0+(`len_q`-GAP_TICKS)·TICK_DIV.
- `beat_finish`=1 exactly at cycle t0+`len_q`·TICK_DIV. State is DONE and `note_busy`=0 in that same cycle.
- Each cycle with `beat_cnt_en`=0 in RUN delays `beat_finish` by one cycle.
- Soft clear asserted at cycle c: state is IDLE and `buzzer`=0 at c+1, and no `beat_finish` is produced.
- Controller compatibility: `beat_cnt_en` stays high for ≥2 cycles after `beat_finish`. DONE absorbs this, and the next note starts only after `beat_cnt_rstn` has been low for ≥1 cycle.

## Test plan
Bench parameters: TICK_DIV=4, GAP_TICKS=1.
- **Reset.** Hold `rstn`=0 with all enables at 1 → `buzzer`=0, `beat_finish`=0, `note_busy`=0. Release `rstn` → note starts the next cycle (t0).
- **Basic note.** `tune`=3, `beat`=4 → `buzzer` rises at t0+3, falls at t0+6, rises at t0+9; forced 0 from t0+12; `beat_finish` high only at t0+16.
- **Rest and zero beat.**
  - `tune`=0, `beat`=2 → `buzzer` stays 0; `beat_finish` at t0+8.
  - `beat`=0 → `beat_finish` at t0+4.
  - `beat`=1 → no gap; tone runs until t0+4.
- **Pause.** `beat_cnt_en`=0 for 5 cycles starting at t0+6 with `beat`=4 → `beat_finish` at t0+21.
- **Abort.** `beat_cnt_rstn`=0 at t0+7 → IDLE and `buzzer`=0 at t0+8; no `beat_finish`. Reassert with new `tune`=2 → new note uses `tune`=2.
- **DONE hold.** Keep enables high for 10 cycles after `beat_finish` → exactly one pulse, `buzzer`=0. Then `beat_cnt_rstn` low for 1 cycle → a new note starts.
